// File: rtl/iec_sd_arbiter.sv
`default_nettype none
// ============================================================================
// iec_sd_arbiter : round-robin merge of per-drive SD sector requests onto the
//                  single HPS SD channel, one transfer outstanding at a time.
// Revision       : 1.0
// ============================================================================
module iec_sd_arbiter #(
  parameter  int DRIVES = 2,
  localparam int NDR    = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES),
  localparam int N      = NDR - 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [31:0] drv_lba      [NDR],
  input  logic [5:0]  drv_blk_cnt  [NDR],
  input  logic [N:0]  drv_rd,
  input  logic [N:0]  drv_wr,
  output logic [N:0]  drv_ack,
  input  logic [7:0]  drv_buff_din [NDR],
  output logic [31:0] sd_lba,
  output logic [5:0]  sd_blk_cnt,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic [7:0]  sd_buff_din,
  output logic        busy,
  output logic [1:0]  cur_drive
);

  localparam int SW = (NDR > 1) ? $clog2(NDR) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0] sd_lba_q, sd_lba_d;
  logic [5:0]  sd_blk_cnt_q, sd_blk_cnt_d;
  logic        sd_rd_q, sd_rd_d;
  logic        sd_wr_q, sd_wr_d;

  logic [N:0]  pend;
  logic [2:0]  cand;
  logic        win_found;
  logic [1:0]  win_idx;

  // Round-robin scan starting at rr_ptr, wrapping modulo NDR.
  always_comb begin
    pend      = drv_rd | drv_wr;
    cand      = 3'd0;
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int k = 0; k < NDR; k++) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'(NDR)) begin
        cand = cand - 3'(NDR);
      end
      if (!win_found && pend[cand[SW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    sd_lba_d     = sd_lba_q;
    sd_blk_cnt_d = sd_blk_cnt_q;
    sd_rd_d      = sd_rd_q;
    sd_wr_d      = sd_wr_q;
    case (state_q)
      ST_IDLE: begin
        // A stale ack left over from an aborted transfer must clear first.
        if (win_found && !sd_ack) begin
          sel_d        = win_idx;
          sd_lba_d     = drv_lba[win_idx[SW-1:0]];
          sd_blk_cnt_d = drv_blk_cnt[win_idx[SW-1:0]];
          sd_wr_d      = drv_wr[win_idx[SW-1:0]];
          sd_rd_d      = drv_rd[win_idx[SW-1:0]] & ~drv_wr[win_idx[SW-1:0]];
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!sd_ack) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (sel_q == 2'(N)) ? 2'd0 : sel_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= 2'd0;
      rr_ptr_q     <= 2'd0;
      sd_lba_q     <= 32'd0;
      sd_blk_cnt_q <= 6'd0;
      sd_rd_q      <= 1'b0;
      sd_wr_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      sd_lba_q     <= sd_lba_d;
      sd_blk_cnt_q <= sd_blk_cnt_d;
      sd_rd_q      <= sd_rd_d;
      sd_wr_q      <= sd_wr_d;
    end
  end

  always_comb begin
    drv_ack = '0;
    for (int i = 0; i < NDR; i++) begin
      drv_ack[i] = sd_ack & busy & (sel_q == 2'(i));
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign sd_buff_din = drv_buff_din[sel_q[SW-1:0]];
  assign sd_lba      = sd_lba_q;
  assign sd_blk_cnt  = sd_blk_cnt_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign cur_drive   = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_iec_sd_arbiter.sv
`default_nettype none
// ============================================================================
// tb_iec_sd_arbiter : directed scenarios plus random traffic against a
//                     transaction-level reference of the arbiter.
// Revision          : 1.0
// ============================================================================
module tb_iec_sd_arbiter;

  localparam int NDR = 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] drv_lba      [NDR];
  logic [5:0]  drv_blk_cnt  [NDR];
  logic [1:0]  drv_rd;
  logic [1:0]  drv_wr;
  logic [1:0]  drv_ack;
  logic [7:0]  drv_buff_din [NDR];
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_din;
  logic        busy;
  logic [1:0]  cur_drive;

  iec_sd_arbiter #(.DRIVES(NDR)) u_dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_lba      (drv_lba),
    .drv_blk_cnt  (drv_blk_cnt),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .cur_drive    (cur_drive)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_mis = 0;

  // Reference: a request is either waiting for the HPS ack, or being transferred.
  bit          m_waiting = 1'b0;
  bit          m_transfer = 1'b0;
  int          m_sel = 0;
  int          m_ptr = 0;
  logic [31:0] m_lba = '0;
  logic [5:0]  m_blk = '0;
  bit          m_rd = 1'b0;
  bit          m_wr = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    int w;
    if (reset) begin
      m_waiting = 0; m_transfer = 0; m_sel = 0; m_ptr = 0;
      m_lba = '0; m_blk = '0; m_rd = 0; m_wr = 0;
    end else if (!m_waiting && !m_transfer) begin
      w = -1;
      for (int k = 0; k < NDR; k++) begin
        int idx;
        idx = (m_ptr + k) % NDR;
        if (w < 0 && (drv_rd[idx] || drv_wr[idx])) w = idx;
      end
      if (w >= 0 && !sd_ack) begin
        m_sel = w;
        m_lba = drv_lba[w];
        m_blk = drv_blk_cnt[w];
        m_wr  = drv_wr[w];
        m_rd  = drv_rd[w] && !drv_wr[w];
        m_waiting = 1;
      end
    end else if (m_waiting) begin
      if (sd_ack) begin
        m_rd = 0; m_wr = 0; m_waiting = 0; m_transfer = 1;
      end
    end else if (!sd_ack) begin
      m_transfer = 0;
      m_ptr = (m_sel + 1) % NDR;
    end
  endtask

  task automatic check_comb();
    logic [1:0] exp_ack;
    exp_ack = (sd_ack && (m_waiting || m_transfer)) ? 2'(1 << m_sel) : 2'b00;
    check("drv_ack", drv_ack, exp_ack);
    check("sd_buff_din", sd_buff_din, drv_buff_din[m_sel]);
    check("ack_onehot", 64'($countones(drv_ack) <= 1), 64'd1);
  endtask

  task automatic check_regs();
    check("sd_rd", sd_rd, m_rd);
    check("sd_wr", sd_wr, m_wr);
    check("sd_lba", sd_lba, m_lba);
    check("sd_blk_cnt", sd_blk_cnt, m_blk);
    check("cur_drive", cur_drive, 2'(m_sel));
    check("busy", busy, m_waiting || m_transfer);
  endtask

  // Called 1 time unit after a rising edge, once the inputs for the next edge are set.
  task automatic tick();
    #1;
    check_comb();
    @(posedge clk_sys);
    model_update();
    #1;
    check_regs();
  endtask

  initial begin
    int grants [$];
    int hold;
    int budget;

    reset = 1'b1; sd_ack = 1'b0; drv_rd = '0; drv_wr = '0;
    for (int i = 0; i < NDR; i++) begin
      drv_lba[i] = '0; drv_blk_cnt[i] = '0; drv_buff_din[i] = '0;
    end
    @(posedge clk_sys);
    model_update();
    #1;
    check_regs();
    check("rst_busy", busy, 1'b0);

    // Basic read on drive 0
    reset = 1'b0;
    drv_lba[0] = 32'h1234; drv_blk_cnt[0] = 6'd3; drv_rd = 2'b01;
    tick();
    check("t1_rd", sd_rd, 1'b1);
    check("t1_lba", sd_lba, 32'h1234);
    check("t1_blk", sd_blk_cnt, 6'd3);
    sd_ack = 1'b1; drv_rd = 2'b00;
    tick();
    check("t1_rd_drop", sd_rd, 1'b0);
    check("t1_ack", drv_ack, 2'b01);
    sd_ack = 1'b0;
    tick();
    check("t1_idle", busy, 1'b0);

    // Write on drive 1, data muxed from drive 1
    drv_wr = 2'b10; drv_buff_din[1] = 8'hA5; drv_buff_din[0] = 8'h5A;
    tick();
    check("t3_wr", sd_wr, 1'b1);
    check("t3_rd", sd_rd, 1'b0);
    sd_ack = 1'b1; drv_wr = 2'b00;
    tick();
    check("t3_ack", drv_ack, 2'b10);
    check("t3_din", sd_buff_din, 8'hA5);
    tick();
    check("t3_din_hold", sd_buff_din, 8'hA5);
    sd_ack = 1'b0;
    tick();

    // rd+wr together: write wins
    drv_rd = 2'b01; drv_wr = 2'b01;
    tick();
    check("t5_wr", sd_wr, 1'b1);
    check("t5_rd", sd_rd, 1'b0);
    drv_rd = 2'b00; drv_wr = 2'b00; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();

    // One-cycle request pulse is latched; pointer then wraps to drive 0
    drv_rd = 2'b10;
    tick();
    drv_rd = 2'b00;
    tick();
    tick();
    check("t6_rd_held", sd_rd, 1'b1);
    sd_ack = 1'b1;
    tick();
    check("t6_ack", drv_ack, 2'b10);
    sd_ack = 1'b0;
    tick();
    drv_rd = 2'b11;
    tick();
    check("t6_ptr_wrap", cur_drive, 2'd0);
    drv_rd = 2'b00; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();

    // Reset mid-transfer with ack still high: stale ack blocks re-grant
    drv_rd = 2'b01;
    tick();
    sd_ack = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_rd", sd_rd, 1'b0);
    check("t4_rst_lba", sd_lba, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("t4_stale_rd", sd_rd, 1'b0);
    check("t4_stale_ack", drv_ack, 2'b00);
    sd_ack = 1'b0;
    tick();
    check("t4_regrant", sd_rd, 1'b1);
    drv_rd = 2'b00; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();

    // Round-robin with both drives requesting continuously from reset
    reset = 1'b1;
    tick();
    reset = 1'b0; drv_rd = 2'b11; hold = 0; budget = 0;
    while (grants.size() < 3 && budget < 100) begin
      tick();
      budget++;
      if (sd_rd) begin
        grants.push_back(int'(cur_drive));
        sd_ack = 1'b1; hold = 2;
      end else if (hold > 0) begin
        hold--;
      end else begin
        sd_ack = 1'b0;
      end
    end
    check("t2_grant_count", grants.size(), 3);
    if (grants.size() == 3) begin
      check("t2_grant0", grants[0], 0);
      check("t2_grant1", grants[1], 1);
      check("t2_grant2", grants[2], 0);
    end
    drv_rd = 2'b00; sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) begin
        drv_rd = 2'($urandom);
        drv_wr = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      end
      for (int i = 0; i < NDR; i++) begin
        drv_lba[i]      = $urandom;
        drv_blk_cnt[i]  = 6'($urandom);
        drv_buff_din[i] = 8'($urandom);
      end
      if ((m_rd || m_wr) && $urandom_range(0, 1) == 0) sd_ack = 1'b1;
      else if (sd_ack && $urandom_range(0, 2) == 0) sd_ack = 1'b0;
      else if ($urandom_range(0, 49) == 0) sd_ack = ~sd_ack;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
